// File: rtl/image_load_if.sv
// AXI4-Lite write slave, pixel-buffer port and pixel stream bundle for image_load_ctrl.
// Pure wiring; no latency of its own.
// Backpressure is carried by the valid/ready pairs (AW/W/B and the pixel stream).
interface image_load_if #(parameter int PIX_W = 8);
  logic [31:0]      awaddr;
  logic             awvalid;
  logic             awready;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic             pix_we;
  logic [7:0]       pix_waddr;
  logic [PIX_W-1:0] pix_wdata;
  logic [7:0]       pix_raddr;
  logic [PIX_W-1:0] pix_rdata;
  logic             pix_out_valid;
  logic             pix_out_ready;
  logic [PIX_W-1:0] pix_out_data;
  logic [7:0]       pix_out_idx;
  logic             pix_out_last;
  logic             busy;
  logic             img_done;

  // Side that drives AXI requests, serves the buffer and consumes the stream.
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, pix_rdata, pix_out_ready,
    input  awready, wready, bresp, bvalid, pix_we, pix_waddr, pix_wdata, pix_raddr,
           pix_out_valid, pix_out_data, pix_out_idx, pix_out_last, busy, img_done
  );

  // Controller side.
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, pix_rdata, pix_out_ready,
    output awready, wready, bresp, bvalid, pix_we, pix_waddr, pix_wdata, pix_raddr,
           pix_out_valid, pix_out_data, pix_out_idx, pix_out_last, busy, img_done
  );
endinterface

// File: rtl/image_load_ctrl.sv
// Loads an image into an external pixel buffer over AXI4-Lite and streams it out on START.
// Latency: PIX_WE one cycle after accept; stream beats every 2 cycles (fetch + send) minimum.
// Backpressure: AW/W accepted only together and only in W_IDLE; stream holds its beat until pix_out_ready.
module image_load_ctrl #(
  parameter int NPIX  = 256,
  parameter int PIX_W = 8
) (
  input logic       aclk,
  input logic       aresetn,
  image_load_if.slave bus
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} sstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] LAST_IDX    = 8'(NPIX - 1);

  wstate_t    wstate;
  sstate_t    sstate;
  logic [7:0] idx;
  logic       busy_q;
  logic       out_vld;
  logic       accept;
  logic       is_pix;
  logic       is_ctrl;
  logic       start_req;
  logic       unused_bits;

  // Both channels are taken in the same cycle, and only while idle and out of reset.
  assign accept      = aresetn && (wstate == W_IDLE) && bus.awvalid && bus.wvalid;
  assign bus.awready = accept;
  assign bus.wready  = accept;

  assign is_pix    = (bus.awaddr[11:10] == 2'b00);
  assign is_ctrl   = (bus.awaddr[11:0] == 12'h400);
  // BUSY is sampled at the accept cycle, so a start and a pixel write can never overlap.
  assign start_req = accept && is_ctrl && !busy_q && bus.wstrb[0] && bus.wdata[0];

  assign bus.busy          = busy_q;
  assign bus.pix_raddr     = idx;
  assign bus.pix_out_valid = out_vld;
  // Buffer read data arrives during S_SEND and stays put while idx is held.
  assign bus.pix_out_data  = out_vld ? bus.pix_rdata : '0;

  // Address bits above the 4 KB window, upper data bytes and upper strobes carry no meaning here.
  assign unused_bits = ^{bus.awaddr[31:12], bus.wdata[31:PIX_W], bus.wstrb[3:1]};

  // Write FSM: decode on accept, issue the buffer strobe, hold the response until BREADY.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate        <= W_IDLE;
      bus.bvalid    <= 1'b0;
      bus.bresp     <= RESP_OKAY;
      bus.pix_we    <= 1'b0;
      bus.pix_waddr <= '0;
      bus.pix_wdata <= '0;
    end else begin
      bus.pix_we <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (accept) begin
            wstate     <= W_RESP;
            bus.bvalid <= 1'b1;
            if (is_pix) begin
              if (busy_q) begin
                bus.bresp <= RESP_SLVERR;
              end else begin
                bus.bresp <= RESP_OKAY;
                if (bus.wstrb[0]) begin
                  bus.pix_we    <= 1'b1;
                  bus.pix_waddr <= bus.awaddr[9:2];
                  bus.pix_wdata <= bus.wdata[PIX_W-1:0];
                end
              end
            end else if (is_ctrl) begin
              bus.bresp <= busy_q ? RESP_SLVERR : RESP_OKAY;
            end else begin
              bus.bresp <= RESP_SLVERR;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            wstate     <= W_IDLE;
            bus.bvalid <= 1'b0;
            bus.bresp  <= RESP_OKAY;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Stream FSM: one fetch cycle to cover buffer read latency, then present the beat until taken.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sstate           <= S_IDLE;
      idx              <= '0;
      busy_q           <= 1'b0;
      out_vld          <= 1'b0;
      bus.pix_out_idx  <= '0;
      bus.pix_out_last <= 1'b0;
      bus.img_done     <= 1'b0;
    end else begin
      bus.img_done <= 1'b0;
      case (sstate)
        S_IDLE: begin
          if (start_req) begin
            idx    <= '0;
            busy_q <= 1'b1;
            sstate <= S_FETCH;
          end
        end
        S_FETCH: begin
          out_vld          <= 1'b1;
          bus.pix_out_idx  <= idx;
          bus.pix_out_last <= (idx == LAST_IDX);
          sstate           <= S_SEND;
        end
        S_SEND: begin
          if (bus.pix_out_ready) begin
            out_vld          <= 1'b0;
            bus.pix_out_last <= 1'b0;
            if (idx == LAST_IDX) begin
              // idx stays at the last index; the next START reloads it.
              sstate       <= S_IDLE;
              busy_q       <= 1'b0;
              bus.img_done <= 1'b1;
            end else begin
              idx    <= idx + 8'd1;
              sstate <= S_FETCH;
            end
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Directed bench for image_load_ctrl with a pixel-buffer model and a stream scoreboard.
module tb_image_load_ctrl;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  image_load_if #(.PIX_W(8)) bus ();

  image_load_ctrl #(.NPIX(256), .PIX_W(8)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  // External pixel buffer: synchronous write, one-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] rdata_q = '0;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.pix_we) mem[bus.pix_waddr] <= bus.pix_wdata;
    rdata_q <= mem[bus.pix_raddr];
  end
  assign bus.pix_rdata = rdata_q;

  int    passed = 0;
  int    total = 0;
  int    failed = 0;
  int    n_writes = 0;
  int    exp_we_total = 0;
  int    acc_cnt = 0;
  int    we_cnt = 0;
  int    done_cnt = 0;
  int    busy_cyc = 0;
  int    beat_cnt = 0;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic push_image();
    for (int i = 0; i < 256; i++) begin
      beat_t b;
      b.idx  = 8'(i);
      b.data = pat(i);
      b.last = (i == 255);
      exp_q.push_back(b);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_awready"}, 32'(bus.awready), 0);
    chk({tag, "_wready"}, 32'(bus.wready), 0);
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 0);
    chk({tag, "_bresp"}, 32'(bus.bresp), 0);
    chk({tag, "_pix_we"}, 32'(bus.pix_we), 0);
    chk({tag, "_pix_waddr"}, 32'(bus.pix_waddr), 0);
    chk({tag, "_pix_wdata"}, 32'(bus.pix_wdata), 0);
    chk({tag, "_pix_raddr"}, 32'(bus.pix_raddr), 0);
    chk({tag, "_out_valid"}, 32'(bus.pix_out_valid), 0);
    chk({tag, "_out_data"}, 32'(bus.pix_out_data), 0);
    chk({tag, "_out_idx"}, 32'(bus.pix_out_idx), 0);
    chk({tag, "_out_last"}, 32'(bus.pix_out_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_img_done"}, 32'(bus.img_done), 0);
  endtask

  // Full AXI write: optional AW lead, accept, strobe timing, response hold, no accept in W_RESP.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input logic [1:0] exp_resp, input bit exp_we);
    n_writes++;
    if (exp_we) exp_we_total++;
    @(posedge clk); #1;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    for (int k = 0; k < aw_lead; k++) begin
      @(negedge clk);
      chk("aw_alone_awready", 32'(bus.awready), 0);
      chk("aw_alone_wready", 32'(bus.wready), 0);
      @(posedge clk); #1;
    end
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.awready && bus.wready) break;
      @(posedge clk); #1;
    end
    chk("accept", 32'(bus.awready & bus.wready), 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    chk("pix_we", 32'(bus.pix_we), 32'(exp_we));
    if (exp_we) begin
      chk("pix_waddr", 32'(bus.pix_waddr), 32'(addr[9:2]));
      chk("pix_wdata", 32'(bus.pix_wdata), 32'(data[7:0]));
    end
    chk("bvalid", 32'(bus.bvalid), 1);
    chk("bresp", 32'(bus.bresp), 32'(exp_resp));
    @(posedge clk); #1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    chk("pix_we_pulse", 32'(bus.pix_we), 0);
    chk("bvalid_hold", 32'(bus.bvalid), 1);
    chk("bresp_hold", 32'(bus.bresp), 32'(exp_resp));
    chk("resp_no_accept", 32'(bus.awready | bus.wready), 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("bvalid_clear", 32'(bus.bvalid), 0);
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_stream_end(input string tag, input int d0, input int b0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    chk({tag, "_beats"}, 32'(beat_cnt - b0), 256);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_busy_after"}, 32'(bus.busy), 0);
  endtask

  // Monitor: counters, stall stability, and scoreboard pops on each stream handshake.
  initial begin
    beat_t      b;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] prev_idx = '0;
    logic       prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.awvalid && bus.awready) acc_cnt++;
        if (bus.pix_we) we_cnt++;
        if (bus.img_done) done_cnt++;
        if (bus.busy) busy_cyc++;
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.pix_out_valid), 1);
          chk("stall_data", 32'(bus.pix_out_data), 32'(prev_data));
          chk("stall_idx", 32'(bus.pix_out_idx), 32'(prev_idx));
          chk("stall_last", 32'(bus.pix_out_last), 32'(prev_last));
        end
        if (bus.pix_out_valid && bus.pix_out_ready) begin
          beat_cnt++;
          chk("beat_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("beat_idx", 32'(bus.pix_out_idx), 32'(b.idx));
            chk("beat_data", 32'(bus.pix_out_data), 32'(b.data));
            chk("beat_last", 32'(bus.pix_out_last), 32'(b.last));
          end
        end
        prev_stall = bus.pix_out_valid && !bus.pix_out_ready;
        prev_data  = bus.pix_out_data;
        prev_idx   = bus.pix_out_idx;
        prev_last  = bus.pix_out_last;
      end
    end
  end

  initial begin
    int d0;
    int b0;
    rst_n             = 1'b0;
    bus.awaddr        = '0;
    bus.awvalid       = 1'b0;
    bus.wdata         = '0;
    bus.wstrb         = '0;
    bus.wvalid        = 1'b0;
    bus.bready        = 1'b0;
    bus.pix_out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single pixel write, then AW leading W by 3 cycles, then a write with byte 0 disabled.
    axi_write(32'h008, 32'h0000_00A5, 4'hF, 0, OKAY, 1'b1);
    axi_write(32'h00C, 32'h0000_005A, 4'hF, 3, OKAY, 1'b1);
    axi_write(32'h010, 32'h0000_0077, 4'hE, 0, OKAY, 1'b0);

    // Load the whole image; upper data bytes must be ignored.
    for (int i = 0; i < 256; i++)
      axi_write(32'(i * 4), 32'hABCD_EF00 | 32'(pat(i)), 4'hF, 0, OKAY, 1'b1);

    // CTRL without START, and two unmapped addresses.
    axi_write(32'h400, 32'h0000_0000, 4'hF, 0, OKAY, 1'b0);
    @(negedge clk);
    chk("ctrl_zero_no_busy", 32'(bus.busy), 0);
    axi_write(32'h800, 32'h0000_0001, 4'hF, 0, SLVERR, 1'b0);
    axi_write(32'h404, 32'h0000_0001, 4'hF, 0, SLVERR, 1'b0);
    @(negedge clk);
    chk("bad_addr_no_busy", 32'(bus.busy), 0);

    // Full-rate stream.
    bus.pix_out_ready = 1'b1;
    @(posedge clk); #1;
    busy_cyc = 0;
    d0 = done_cnt;
    b0 = beat_cnt;
    push_image();
    axi_write(32'h400, 32'h0000_0001, 4'hF, 0, OKAY, 1'b0);
    wait_done(d0);
    chk("full_busy_cycles", 32'(busy_cyc), 512);
    chk_stream_end("full", d0, b0);

    // Stalled stream with rejected writes, then random backpressure.
    bus.pix_out_ready = 1'b0;
    d0 = done_cnt;
    b0 = beat_cnt;
    push_image();
    axi_write(32'h400, 32'h0000_0001, 4'hF, 0, OKAY, 1'b0);
    axi_write(32'h014, 32'h0000_003C, 4'hF, 0, SLVERR, 1'b0);
    axi_write(32'h400, 32'h0000_0001, 4'hF, 0, SLVERR, 1'b0);
    axi_write(32'h400, 32'h0000_0000, 4'hF, 0, SLVERR, 1'b0);
    axi_write(32'h800, 32'h0000_0001, 4'hF, 0, SLVERR, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      bus.pix_out_ready = 1'($urandom_range(0, 1));
      if (done_cnt != d0) break;
    end
    bus.pix_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_stream_end("random", d0, b0);

    // Reset around beat 100 with a write response pending.
    d0 = done_cnt;
    b0 = beat_cnt;
    push_image();
    axi_write(32'h400, 32'h0000_0001, 4'hF, 0, OKAY, 1'b0);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (beat_cnt - b0 >= 100) break;
    end
    chk("reached_beat_100", 32'(beat_cnt - b0 >= 100), 1);
    n_writes++;
    bus.awaddr  = 32'h800;
    bus.wdata   = 32'h1;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.awready && bus.wready) break;
      @(posedge clk); #1;
    end
    chk("mid_accept", 32'(bus.awready & bus.wready), 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    chk("mid_bvalid_pending", 32'(bus.bvalid), 1);
    chk("mid_busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_bvalid", 32'(bus.bvalid), 0);
    chk("post_reset_busy", 32'(bus.busy), 0);
    chk("post_reset_no_done", 32'(done_cnt - d0), 0);

    // Restart must begin again at index 0.
    d0 = done_cnt;
    b0 = beat_cnt;
    push_image();
    axi_write(32'h400, 32'h0000_0001, 4'hF, 0, OKAY, 1'b0);
    wait_done(d0);
    chk_stream_end("restart", d0, b0);

    chk("accept_count", 32'(acc_cnt), 32'(n_writes));
    chk("pix_we_count", 32'(we_cnt), 32'(exp_we_total));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/image_load_ctrl.md
IMAGE_LOAD_CTRL -- requirements
Module: image_load_ctrl

Interface
REQ-001 Parameter NPIX, default 256, number of 8-bit pixels per image.
REQ-002 Parameter PIX_W, default 8, pixel width in bits.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETN  input  1  reset, synchronous, active-low.
REQ-005 AWADDR  input  32  AXI4-Lite write address.
REQ-006 AWVALID / AWREADY  input / output  1 / 1  write-address handshake.
REQ-007 WDATA  input  32  write data.
REQ-008 WSTRB  input  4  byte strobes.
REQ-009 WVALID / WREADY  input / output  1 / 1  write-data handshake.
REQ-010 BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-011 BVALID / BREADY  output / input  1 / 1  write-response handshake.
REQ-012 PIX_WE  output  1  one-cycle write strobe to the external pixel buffer.
REQ-013 PIX_WADDR  output  8  buffer write index.
REQ-014 PIX_WDATA  output  PIX_W  buffer write data, equal to WDATA[7:0].
REQ-015 PIX_RADDR  output  8  buffer read index; the buffer returns data one cycle later.
REQ-016 PIX_RDATA  input  PIX_W  buffer read data.
REQ-017 PIX_OUT_VALID / PIX_OUT_READY  output / input  1 / 1  pixel stream handshake toward the SNN core.
REQ-018 PIX_OUT_DATA / PIX_OUT_IDX  output  PIX_W / 8  streamed pixel value and index.
REQ-019 PIX_OUT_LAST  output  1  high with the beat whose index is NPIX-1.
REQ-020 BUSY  output  1  streaming in progress.
REQ-021 IMG_DONE  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-022 Address map (AWADDR[11:0]): 0x000-0x3FF is the pixel area, with index AWADDR[9:2]; 0x400 is CTRL, where bit0 = START; any other address returns SLVERR with no side effect.
REQ-023 Write FSM states W_IDLE and W_RESP; AWREADY and WREADY are both high for exactly the single cycle in W_IDLE when AWVALID and WVALID are both high; that cycle is the accept cycle.
REQ-024 An AW or W valid without its partner is not accepted; READY stays low and the valid is held until the partner arrives.
REQ-025 Accept cycle -> W_RESP next cycle with BVALID=1 and BRESP valid; BVALID and BRESP are held until BREADY, then return to W_IDLE; no new accept is possible while in W_RESP.
REQ-026 Pixel write, not BUSY, WSTRB[0]=1 -> PIX_WE=1 the cycle after accept, with PIX_WADDR = index; OKAY.
REQ-027 Pixel write with WSTRB[0]=0 -> no PIX_WE; OKAY.
REQ-028 Pixel write while BUSY -> no PIX_WE; SLVERR.
REQ-029 CTRL write, WDATA[0]=1, WSTRB[0]=1, not BUSY -> streaming starts; OKAY.
REQ-030 CTRL write while BUSY -> ignored; SLVERR. CTRL write with WDATA[0]=0 -> no effect; OKAY.
REQ-031 Stream FSM states S_IDLE, S_FETCH and S_SEND; on START, idx<=0 and S_IDLE->S_FETCH in the cycle after accept, with BUSY=1 from that cycle.
REQ-032 PIX_RADDR equals the idx register at all times; S_FETCH lasts one cycle, then S_SEND.
REQ-033 In S_SEND: PIX_OUT_VALID=1, PIX_OUT_DATA=PIX_RDATA, PIX_OUT_IDX=idx, PIX_OUT_LAST=(idx==NPIX-1).
REQ-034 Stream outputs are stable until PIX_OUT_READY; VALID never drops without a handshake.
REQ-035 Handshake with idx<NPIX-1 -> idx+1, S_FETCH; throughput is one pixel per 2 cycles minimum.
REQ-036 Handshake on the last beat -> S_IDLE, BUSY=0 and IMG_DONE=1 for one cycle in the next cycle; idx does not wrap.
REQ-037 A pixel write and the first S_FETCH are never simultaneous: BUSY is sampled at the accept cycle.

Reset
REQ-038 ARESETN=0 at a rising edge forces W_IDLE and S_IDLE, with idx=0 and all outputs 0 (AWREADY, WREADY, BVALID, BRESP=00, PIX_WE, PIX_WADDR, PIX_WDATA, PIX_RADDR, PIX_OUT_*, BUSY, IMG_DONE).
REQ-039 Reset mid-stream or mid-response aborts the operation: no IMG_DONE, and no pending BVALID after release.

Verification
REQ-040 Write 0xA5 to 0x008 with AW and W valid together -> PIX_WE=1, WADDR=2, WDATA=0xA5 one cycle after accept; BVALID with BRESP=00 until BREADY.
REQ-041 AWVALID 3 cycles before WVALID -> READY low until both are high; exactly one accept.
REQ-042 Write 1 to 0x400, PIX_OUT_READY=1 constant -> 256 beats with idx 0..255, LAST only on idx 255, IMG_DONE one pulse, BUSY high 512 cycles.
REQ-043 Stream with READY toggled randomly -> data and idx stable while stalled; no beat lost or duplicated.
REQ-044 Pixel write and CTRL write while BUSY, and a write to 0x800 -> BRESP=10; no PIX_WE; stream unaffected.
REQ-045 ARESETN low at beat 100 -> all outputs 0; after a restart, the stream begins at idx 0.
